bob_indir_mp: RTL and testbench
===============================

Name: bob_indir_mp

Overview:
- Multi-port successor to the bob indirect data/ready store.
- Holds one DATA_WIDTH payload plus one ready bit per bob entry.
- Generalised to RD_PORTS registered-address read ports and WR_PORTS data write ports, plus one indirect ready-write port.
- Adds a sequential flush walker that clears all ready bits, both after reset and on request.

Parameters:
ADDR_WIDTH, `bob_addr_width, entry index width
ADDR_COUNT, `bob_count, number of entries (must be ≤ 2**ADDR_WIDTH)
DATA_WIDTH, 65, payload width
RD_PORTS, 2, number of read ports
WR_PORTS, 2, number of data write ports

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
read_clkEn  in  RD_PORTS  per-port read address load enable
read_addr  in  RD_PORTS*ADDR_WIDTH  read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
read_data  out  RD_PORTS*DATA_WIDTH  read payloads, port p at [p*DATA_WIDTH +: DATA_WIDTH]
read_ready  out  RD_PORTS  ready bit per read port
write_wen  in  WR_PORTS  data write enables
write_addr  in  WR_PORTS*ADDR_WIDTH  data write addresses
write_data  in  WR_PORTS*DATA_WIDTH  data write payloads
writeI_wen  in  1  indirect ready write enable
writeI_addr  in  ADDR_WIDTH  indirect ready write address
writeI_ready  in  1  value written to the ready bit
flush_req  in  1  start ready-clear walk (level, sampled when idle)
flush_busy  out  1  walk in progress

Behaviour:
- Read path, per port p:
  - addr_reg[p] loads read_addr[p] on the clk edge when read_clkEn[p]=1, else holds.
  - read_data[p] = ram[addr_reg[p]]; read_ready[p] = rdy[addr_reg[p]] & ~flush_busy. Both combinational from the register.
  - A write at edge t is visible to a read whose addr_reg matches after edge t, i.e. 1-cycle write-to-read latency.
- Data write: for each k with write_wen[k]=1, ram[write_addr[k]] <= write_data[k] and rdy[write_addr[k]] <= 1.
- Indirect ready write: writeI_wen=1 sets rdy[writeI_addr] <= writeI_ready; ram is untouched.
- Same-address collisions in one cycle:
  - Among data ports, the highest index k wins, for both data and ready.
  - writeI wins over every data port for the ready bit; the data payload is still written.
- Flush FSM:
  - States: IDLE, WALK; counter cnt[ADDR_WIDTH-1:0].
  - IDLE -> WALK when flush_req=1; cnt <= 0.
  - WALK: rdy[cnt] <= 0 each cycle and cnt increments. When cnt == ADDR_COUNT-1, clear that entry and go to IDLE.
  - flush_busy = (state == WALK).
  - The walk takes exactly ADDR_COUNT cycles; flush_busy drops in the cycle after the last entry is cleared.
  - flush_req during WALK is ignored; the walk does not restart.
  - During WALK, data writes still update ram, but all ready updates from write_wen and writeI_wen are dropped. The walker is the only ready writer.
  - read_ready is forced to 0 while busy.
- Reset:
  - All addr_reg <= 0; state <= WALK; cnt <= 0. Ready bits are therefore initialised by the walker.
  - After rst deasserts: flush_busy=1 and read_ready=0 for ADDR_COUNT cycles, then all ready bits read 0.
  - read_data is undefined until the addressed entry is written.
  - rst asserted mid-walk restarts the walk at cnt=0.
- Ram contents are not reset.

Optional Feature:
BOB_INDIR_BYPASS_EN
- Defined: same-cycle forwarding.
  - If write_wen[k] and write_addr[k] == addr_reg[p], read_data[p] = write_data[k] (highest matching k) and read_ready[p] = 1, subject to ~flush_busy.
  - If writeI_wen and writeI_addr == addr_reg[p] and not busy, read_ready[p] = writeI_ready, overriding the data-port forward.
  - Zero-cycle write-to-read visibility.
- Undefined: no forwarding; the 1-cycle latency above applies.

Test Plan:
1. Reset walk: assert rst 1 cycle -> flush_busy=1 for exactly ADDR_COUNT cycles, read_ready=0 throughout; afterwards read_ready=0 for addresses 0, 5, ADDR_COUNT-1.
2. Basic write/read: write port0 addr 3 data 65'h1_DEAD_BEEF_0000_0001, then read port1 addr 3 -> next cycle read_data[1] equals the value and read_ready[1]=1. Clear via writeI addr 3 ready=0 -> read_ready[1]=0 the following cycle.
3. Collision priority: same cycle write port0 and port1 to addr 7 (data A, B) plus writeI addr 7 ready=0 -> ram[7]=B, rdy[7]=0.
4. Flush: set rdy on addrs 0, 10, 63, pulse flush_req -> busy ADDR_COUNT cycles. A writeI ready=1 to addr 10 issued mid-walk is dropped. All rdy=0 at end, while a data write during the walk is retained.
5. Read enable hold: load addr 2 on port0, deassert read_clkEn, change read_addr to 9 -> read_data[0] keeps tracking entry 2, including a later write to 2.
6. Bypass (macro defined): write addr 4 data C while addr_reg=4 -> read_data=C and read_ready=1 in the same cycle. Macro undefined: visible one cycle later.

Source files
------------

// File: rtl/bob_indir_mp.sv
// bob_indir_mp: multi-port bob data/ready store with a sequential ready-clear flush walker.
// Optional same-cycle write-to-read forwarding when BOB_INDIR_BYPASS_EN is defined.
`ifndef BOB_ADDR_WIDTH
`define BOB_ADDR_WIDTH 6
`endif
`ifndef BOB_COUNT
`define BOB_COUNT 64
`endif
module bob_indir_mp #(
  parameter int ADDR_WIDTH = `BOB_ADDR_WIDTH,
  parameter int ADDR_COUNT = `BOB_COUNT,
  parameter int DATA_WIDTH = 65,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RD_PORTS-1:0]            read_clkEn,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] read_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [RD_PORTS-1:0]            read_ready,
  input  logic [WR_PORTS-1:0]            write_wen,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0] write_addr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] write_data,
  input  logic                           writeI_wen,
  input  logic [ADDR_WIDTH-1:0]          writeI_addr,
  input  logic                           writeI_ready,
  input  logic                           flush_req,
  output logic                           flush_busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WALK = 1'b1;
  logic [DATA_WIDTH-1:0] ram [ADDR_COUNT];
  logic [ADDR_COUNT-1:0] rdy;
  logic [ADDR_WIDTH-1:0] addr_reg [RD_PORTS];
  logic [0:0] state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [RD_PORTS-1:0] rr;
  assign flush_busy = state == WALK;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WALK;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (flush_req) begin
        state <= WALK;
        cnt <= '0;
      end
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == ADDR_WIDTH'(ADDR_COUNT - 1)) state <= IDLE;
    end
  end
  always_ff @(posedge clk)
    for (int p = 0; p < RD_PORTS; p++)
      if (rst) addr_reg[p] <= '0;
      else if (read_clkEn[p]) addr_reg[p] <= read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
  // later ports overwrite earlier ones, so the highest index wins a collision
  always_ff @(posedge clk)
    for (int k = 0; k < WR_PORTS; k++)
      if (write_wen[k]) ram[write_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= write_data[k*DATA_WIDTH +: DATA_WIDTH];
  always_ff @(posedge clk) begin
    if (flush_busy) rdy[cnt] <= 1'b0;
    else begin
      for (int k = 0; k < WR_PORTS; k++)
        if (write_wen[k]) rdy[write_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b1;
      if (writeI_wen) rdy[writeI_addr] <= writeI_ready;
    end
  end
  always_comb begin
    read_data = '0;
    rr = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      read_data[p*DATA_WIDTH +: DATA_WIDTH] = ram[addr_reg[p]];
      rr[p] = rdy[addr_reg[p]];
`ifdef BOB_INDIR_BYPASS_EN
      for (int k = 0; k < WR_PORTS; k++)
        if (write_wen[k] && write_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == addr_reg[p]) begin
          read_data[p*DATA_WIDTH +: DATA_WIDTH] = write_data[k*DATA_WIDTH +: DATA_WIDTH];
          rr[p] = 1'b1;
        end
      if (writeI_wen && writeI_addr == addr_reg[p]) rr[p] = writeI_ready;
`endif
    end
    read_ready = rr & {RD_PORTS{~flush_busy}};
  end
endmodule

// File: tb/tb_bob_indir_mp.sv
// tb_bob_indir_mp: directed self-checking bench for bob_indir_mp (64 entries, 65-bit payload).
module tb_bob_indir_mp;
  localparam int AW = 6;
  localparam int DW = 65;
  localparam int N = 64;
  logic clk = 0;
  logic rst;
  logic [1:0] read_clkEn;
  logic [2*AW-1:0] read_addr;
  logic [2*DW-1:0] read_data;
  logic [1:0] read_ready;
  logic [1:0] write_wen;
  logic [2*AW-1:0] write_addr;
  logic [2*DW-1:0] write_data;
  logic writeI_wen;
  logic [AW-1:0] writeI_addr;
  logic writeI_ready;
  logic flush_req;
  logic flush_busy;
  int total = 0;
  int bad = 0;
  int n;
  logic rflag;
  localparam logic [DW-1:0] D1 = 65'h1_DEAD_BEEF_0000_0001;
  localparam logic [DW-1:0] DA = 65'h0_AAAA_AAAA_AAAA_AAAA;
  localparam logic [DW-1:0] DB = 65'h1_BBBB_BBBB_BBBB_BBBB;
  localparam logic [DW-1:0] DE = 65'h1_EEEE_0000_EEEE_0020;
  localparam logic [DW-1:0] DF = 65'h0_F00D_F00D_F00D_0002;
  localparam logic [DW-1:0] DH = 65'h1_1234_5678_9ABC_DEF0;
  always #5 clk = ~clk;
  bob_indir_mp dut (
    .clk(clk), .rst(rst), .read_clkEn(read_clkEn), .read_addr(read_addr),
    .read_data(read_data), .read_ready(read_ready), .write_wen(write_wen),
    .write_addr(write_addr), .write_data(write_data), .writeI_wen(writeI_wen),
    .writeI_addr(writeI_addr), .writeI_ready(writeI_ready), .flush_req(flush_req),
    .flush_busy(flush_busy)
  );
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    write_wen = 0;
    writeI_wen = 0;
    flush_req = 0;
    read_clkEn = 0;
  endtask
  initial begin
    rst = 1;
    read_clkEn = 0; read_addr = 0; write_wen = 0; write_addr = 0; write_data = 0;
    writeI_wen = 0; writeI_addr = 0; writeI_ready = 0; flush_req = 0;
    step;
    rst = 0;
    n = 0; rflag = 0;
    for (int i = 0; i < 200 && flush_busy; i++) begin
      n++;
      if (read_ready !== 2'b00) rflag = 1;
      step;
    end
    chk("reset_walk_len", DW'(n), DW'(N));
    chk("reset_walk_ready0", DW'(rflag), 0);
    read_clkEn = 2'b11; read_addr = {6'd5, 6'd0};
    step;
    chk("reset_rdy_0_5", DW'(read_ready), 0);
    read_addr = {6'd5, 6'd63};
    step;
    chk("reset_rdy_63", DW'(read_ready[0]), 0);
    idle_in;
    write_wen = 2'b01; write_addr = {6'd0, 6'd3}; write_data = {{DW{1'b0}}, D1};
    read_clkEn = 2'b10; read_addr = {6'd3, 6'd0};
    step;
    idle_in;
    chk("wr_rd_data", read_data[2*DW-1:DW], D1);
    chk("wr_rd_ready", DW'(read_ready[1]), 1);
    writeI_wen = 1; writeI_addr = 3; writeI_ready = 0;
    step;
    idle_in;
    chk("writeI_clear", DW'(read_ready[1]), 0);
    write_wen = 2'b11; write_addr = {6'd7, 6'd7}; write_data = {DB, DA};
    writeI_wen = 1; writeI_addr = 7; writeI_ready = 0;
    read_clkEn = 2'b01; read_addr = {6'd3, 6'd7};
    step;
    idle_in;
    chk("coll_data", read_data[DW-1:0], DB);
    chk("coll_ready", DW'(read_ready[0]), 0);
    write_wen = 2'b11; write_addr = {6'd10, 6'd0}; write_data = {DA, DB};
    step;
    write_wen = 2'b01; write_addr = {6'd0, 6'd63};
    read_clkEn = 2'b11; read_addr = {6'd63, 6'd10};
    step;
    idle_in;
    chk("pre_flush_ready", DW'(read_ready), 2'b11);
    flush_req = 1;
    step;
    flush_req = 0;
    chk("flush_busy_start", DW'(flush_busy), 1);
    n = 0; rflag = 0;
    for (int i = 0; i < 200 && flush_busy; i++) begin
      n++;
      if (read_ready !== 2'b00) rflag = 1;
      idle_in;
      if (i == 40) begin
        writeI_wen = 1; writeI_addr = 10; writeI_ready = 1;
        write_wen = 2'b10; write_addr = {6'd20, 6'd0}; write_data = {DE, {DW{1'b0}}};
      end
      if (i == 45) flush_req = 1;
      step;
    end
    idle_in;
    chk("flush_len", DW'(n), DW'(N));
    chk("flush_ready0", DW'(rflag), 0);
    chk("flush_rdy_10_63", DW'(read_ready), 0);
    read_clkEn = 2'b11; read_addr = {6'd20, 6'd0};
    step;
    idle_in;
    chk("flush_data_kept", read_data[2*DW-1:DW], DE);
    chk("flush_rdy_0_20", DW'(read_ready), 0);
    read_clkEn = 2'b01; read_addr = {6'd20, 6'd2};
    step;
    read_clkEn = 2'b00; read_addr = {6'd20, 6'd9};
    write_wen = 2'b01; write_addr = {6'd0, 6'd2}; write_data = {{DW{1'b0}}, DF};
    step;
    idle_in;
    chk("hold_data", read_data[DW-1:0], DF);
    chk("hold_ready", DW'(read_ready[0]), 1);
    write_wen = 2'b10; write_addr = {6'd2, 6'd0}; write_data = {DH, {DW{1'b0}}};
    #1;
`ifdef BOB_INDIR_BYPASS_EN
    chk("bypass_data_same", read_data[DW-1:0], DH);
`else
    chk("bypass_data_same", read_data[DW-1:0], DF);
`endif
    step;
    idle_in;
    chk("bypass_data_next", read_data[DW-1:0], DH);
    writeI_wen = 1; writeI_addr = 2; writeI_ready = 0;
    #1;
`ifdef BOB_INDIR_BYPASS_EN
    chk("bypass_ready_same", DW'(read_ready[0]), 0);
`else
    chk("bypass_ready_same", DW'(read_ready[0]), 1);
`endif
    step;
    idle_in;
    chk("bypass_ready_next", DW'(read_ready[0]), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
